// File: rtl/scarv_soc_pkg.sv
// Shared definitions for the SCARV SoC peripheral bus: router states,
// default peripheral base addresses and the slave-index width helper.
package scarv_soc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ERR   = 2'd2,
        ST_FLUSH = 2'd3
    } bus_state_t;

    localparam logic [31:0] UART_BASE = 32'h1000_0000;
    localparam logic [31:0] GPIO_BASE = 32'h1000_1000;

    // clog2 of the slave count, never below 1 so a single-slave build still has an index bit
    function automatic int slv_idx_w(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/scarv_soc_periph_bus_decode.sv
// Address-window decoder: one-hot of the lowest-index matching slave,
// its binary index, and a hit flag.
module scarv_soc_periph_bus_decode
    import scarv_soc_pkg::*;
#(
    parameter int                        NUM_SLV  = 4,
    parameter int                        ADDR_W   = 32,
    parameter logic [NUM_SLV*ADDR_W-1:0] SLV_BASE = '0,
    parameter logic [NUM_SLV*ADDR_W-1:0] SLV_SIZE = '0,
    localparam int                       IDX_W    = slv_idx_w(NUM_SLV)
)(
    input  logic [ADDR_W-1:0]  i_addr,
    output logic [NUM_SLV-1:0] o_onehot,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_hit
);

    logic [NUM_SLV-1:0] w_match;
    logic               w_seen;

    // Window match; the subtraction only counts once addr >= base, so it cannot wrap
    always_comb begin
        w_match = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            w_match[i] = (i_addr >= SLV_BASE[i*ADDR_W +: ADDR_W]) &&
                         ((i_addr - SLV_BASE[i*ADDR_W +: ADDR_W]) < SLV_SIZE[i*ADDR_W +: ADDR_W]);
        end
    end

    // Priority encode: lowest matching index wins
    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        w_seen   = 1'b0;
        for (int i = 0; i < NUM_SLV; i++) begin
            o_onehot[i] = w_match[i] & ~w_seen;
            o_idx       = o_idx | (o_onehot[i] ? IDX_W'(i) : '0);
            w_seen      = w_seen | w_match[i];
        end
        o_hit = w_seen;
    end

endmodule

// File: rtl/scarv_soc_periph_bus.sv
// Single-master, N-slave peripheral bus router with bus-error capture.
// Optional macro SCARV_SOC_PERIPH_BUS_TIMEOUT_EN adds the response timeout and FLUSH state.
module scarv_soc_periph_bus
    import scarv_soc_pkg::*;
#(
    parameter int                        NUM_SLV  = 4,
    parameter int                        ADDR_W   = 32,
    parameter int                        DATA_W   = 32,
    parameter logic [NUM_SLV*ADDR_W-1:0] SLV_BASE = {32'h1000_3000, 32'h1000_2000, 32'h1000_1000, 32'h1000_0000},
    parameter logic [NUM_SLV*ADDR_W-1:0] SLV_SIZE = {4{32'h0000_1000}},
    parameter int                        TIMEOUT  = 255
)(
    input  logic                      f_clk,
    input  logic                      g_reset,
    input  logic                      m_req,
    output logic                      m_gnt,
    input  logic                      m_wen,
    input  logic [DATA_W/8-1:0]       m_strb,
    input  logic [ADDR_W-1:0]         m_addr,
    input  logic [DATA_W-1:0]         m_wdata,
    output logic                      m_recv,
    input  logic                      m_ack,
    output logic                      m_error,
    output logic [DATA_W-1:0]         m_rdata,
    output logic [NUM_SLV-1:0]        s_req,
    input  logic [NUM_SLV-1:0]        s_gnt,
    output logic                      s_wen,
    output logic [DATA_W/8-1:0]       s_strb,
    output logic [ADDR_W-1:0]         s_addr,
    output logic [DATA_W-1:0]         s_wdata,
    input  logic [NUM_SLV-1:0]        s_recv,
    output logic [NUM_SLV-1:0]        s_ack,
    input  logic [NUM_SLV-1:0]        s_error,
    input  logic [NUM_SLV*DATA_W-1:0] s_rdata,
    output logic                      err_valid,
    output logic [ADDR_W-1:0]         err_addr,
    input  logic                      err_clr
);

    localparam int IDX_W = slv_idx_w(NUM_SLV);

    bus_state_t         r_state, w_state_nxt;
    logic [IDX_W-1:0]   r_sel, w_sel_nxt;
    logic [ADDR_W-1:0]  r_addr, r_err_addr;
    logic               r_err_valid;
    logic [NUM_SLV-1:0] w_dec_onehot, w_sel_hot;
    logic [IDX_W-1:0]   w_dec_idx;
    logic               w_dec_hit, w_dec_gnt;
    logic               w_sel_recv, w_sel_error;
    logic [DATA_W-1:0]  w_sel_rdata;
    logic               w_accept, w_capture;

`ifdef SCARV_SOC_PERIPH_BUS_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
    logic [15:0] r_cnt, w_cnt_nxt;
    logic        r_to, w_to_nxt;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT != 0);
`endif

    scarv_soc_periph_bus_decode #(
        .NUM_SLV  (NUM_SLV),
        .ADDR_W   (ADDR_W),
        .SLV_BASE (SLV_BASE),
        .SLV_SIZE (SLV_SIZE)
    ) u_decode (
        .i_addr   (m_addr),
        .o_onehot (w_dec_onehot),
        .o_idx    (w_dec_idx),
        .o_hit    (w_dec_hit)
    );

    // Grant of the decoded slave and response fields of the latched slave
    always_comb begin
        w_dec_gnt   = 1'b0;
        w_sel_hot   = '0;
        w_sel_recv  = 1'b0;
        w_sel_error = 1'b0;
        w_sel_rdata = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            w_sel_hot[i] = (IDX_W'(i) == r_sel);
            w_dec_gnt    = w_dec_gnt   | (w_dec_onehot[i] & s_gnt[i]);
            w_sel_recv   = w_sel_recv  | (w_sel_hot[i] & s_recv[i]);
            w_sel_error  = w_sel_error | (w_sel_hot[i] & s_error[i]);
            w_sel_rdata  = w_sel_rdata | (s_rdata[i*DATA_W +: DATA_W] & {DATA_W{w_sel_hot[i]}});
        end
    end

    // Router next state and combinational handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        m_gnt       = 1'b0;
        m_recv      = 1'b0;
        m_error     = 1'b0;
        m_rdata     = '0;
        s_req       = '0;
        s_ack       = '0;
        s_wen       = 1'b0;
        s_strb      = '0;
        s_addr      = '0;
        s_wdata     = '0;
`ifdef SCARV_SOC_PERIPH_BUS_TIMEOUT_EN
        w_cnt_nxt   = r_cnt;
        w_to_nxt    = r_to;
`endif
        case (r_state)
            ST_IDLE: begin
                s_wen   = m_req & m_wen;
                s_strb  = m_req ? m_strb  : '0;
                s_addr  = m_req ? m_addr  : '0;
                s_wdata = m_req ? m_wdata : '0;
                if (w_dec_hit) begin
                    s_req = w_dec_onehot & {NUM_SLV{m_req}};
                    m_gnt = m_req & w_dec_gnt;
                end else begin
                    m_gnt = m_req;
                end
                w_accept = m_gnt;
                if (w_accept) begin
                    w_sel_nxt   = w_dec_hit ? w_dec_idx : r_sel;
                    w_state_nxt = w_dec_hit ? ST_WAIT : ST_ERR;
`ifdef SCARV_SOC_PERIPH_BUS_TIMEOUT_EN
                    w_cnt_nxt   = 16'd0;
                    w_to_nxt    = 1'b0;
`endif
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                m_recv  = w_sel_recv;
                m_error = w_sel_error;
                m_rdata = w_sel_rdata;
                s_ack   = w_sel_hot & {NUM_SLV{m_ack}};
                if (w_sel_recv & m_ack) begin
                    w_state_nxt = ST_IDLE;
                end else begin
`ifdef SCARV_SOC_PERIPH_BUS_TIMEOUT_EN
                    // A response held for the master does not count towards the timeout
                    if (!w_sel_recv) begin
                        w_cnt_nxt   = r_cnt + 16'd1;
                        w_to_nxt    = (r_cnt == TMO_LAST);
                        w_state_nxt = (r_cnt == TMO_LAST) ? ST_ERR : ST_WAIT;
                    end else begin
                        w_state_nxt = ST_WAIT;
                    end
`else
                    w_state_nxt = ST_WAIT;
`endif
                end
            end
            ST_ERR: begin
                m_recv  = 1'b1;
                m_error = 1'b1;
                if (m_ack) begin
                    w_capture = 1'b1;
`ifdef SCARV_SOC_PERIPH_BUS_TIMEOUT_EN
                    w_cnt_nxt   = 16'd0;
                    w_state_nxt = r_to ? ST_FLUSH : ST_IDLE;
`else
                    w_state_nxt = ST_IDLE;
`endif
                end else begin
                    w_state_nxt = ST_ERR;
                end
            end
`ifdef SCARV_SOC_PERIPH_BUS_TIMEOUT_EN
            ST_FLUSH: begin
                s_ack = w_sel_hot;
                if (w_sel_recv) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt   = r_cnt + 16'd1;
                    w_state_nxt = (r_cnt == TMO_LAST) ? ST_IDLE : ST_FLUSH;
                end
            end
`endif
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, selected slave and the address of the accepted request
    always_ff @(posedge f_clk) begin
        if (g_reset) begin
            r_state <= ST_IDLE;
            r_sel   <= '0;
            r_addr  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_addr  <= w_accept ? m_addr : r_addr;
        end
    end

`ifdef SCARV_SOC_PERIPH_BUS_TIMEOUT_EN
    // Timeout counter and the entered-by-timeout marker
    always_ff @(posedge f_clk) begin
        if (g_reset) begin
            r_cnt <= 16'd0;
            r_to  <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_to  <= w_to_nxt;
        end
    end
`endif

    // Sticky error capture; a clear wins over a simultaneous capture
    always_ff @(posedge f_clk) begin
        if (g_reset) begin
            r_err_valid <= 1'b0;
            r_err_addr  <= '0;
        end else if (err_clr) begin
            r_err_valid <= 1'b0;
        end else if (w_capture && !r_err_valid) begin
            r_err_valid <= 1'b1;
            r_err_addr  <= r_addr;
        end
    end

    assign err_valid = r_err_valid;
    assign err_addr  = r_err_addr;

endmodule

// File: tb/tb_scarv_soc_periph_bus.sv
// Directed bench for scarv_soc_periph_bus with a per-cycle expectation model.
module tb_scarv_soc_periph_bus;

    localparam int TMO = 8;
    localparam logic [31:0] M_BASE [4] = '{32'h1000_0000, 32'h1000_1000, 32'h1000_2000, 32'h1000_0000};
    localparam logic [31:0] M_SIZE [4] = '{32'h0000_1000, 32'h0000_1000, 32'h0000_1000, 32'h0000_8000};

    logic         f_clk = 1'b0;
    logic         g_reset;
    logic         m_req, m_gnt, m_wen, m_recv, m_ack, m_error;
    logic [3:0]   m_strb;
    logic [31:0]  m_addr, m_wdata, m_rdata;
    logic [3:0]   s_req, s_gnt, s_recv, s_ack, s_error, s_strb;
    logic         s_wen;
    logic [31:0]  s_addr, s_wdata;
    logic [127:0] s_rdata;
    logic         err_valid, err_clr;
    logic [31:0]  err_addr;

    scarv_soc_periph_bus #(
        .NUM_SLV  (4),
        .ADDR_W   (32),
        .DATA_W   (32),
        .SLV_BASE ({32'h1000_0000, 32'h1000_2000, 32'h1000_1000, 32'h1000_0000}),
        .SLV_SIZE ({32'h0000_8000, 32'h0000_1000, 32'h0000_1000, 32'h0000_1000}),
        .TIMEOUT  (TMO)
    ) dut (
        .f_clk(f_clk), .g_reset(g_reset),
        .m_req(m_req), .m_gnt(m_gnt), .m_wen(m_wen), .m_strb(m_strb),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_recv(m_recv), .m_ack(m_ack),
        .m_error(m_error), .m_rdata(m_rdata),
        .s_req(s_req), .s_gnt(s_gnt), .s_wen(s_wen), .s_strb(s_strb),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_recv(s_recv), .s_ack(s_ack),
        .s_error(s_error), .s_rdata(s_rdata),
        .err_valid(err_valid), .err_addr(err_addr), .err_clr(err_clr)
    );

    always #5 f_clk = ~f_clk;

    int checks = 0;
    int errors = 0;
    logic chk_on = 1'b0;

    // expectations for the current cycle
    logic        e_gnt, e_recv, e_error, e_swen;
    logic [31:0] e_rdata, e_saddr, e_swdata;
    logic [3:0]  e_sreq, e_sack, e_sstrb;
    logic        e_valid = 1'b0;
    logic [31:0] e_eaddr = 32'h0;
    logic        pend_rst = 1'b0, pend_clr = 1'b0, pend_cap = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    logic [31:0] last_rdata = 32'h0;
    logic        last_error = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Lowest index whose window holds the address, in 33-bit arithmetic; -1 on a miss
    function automatic int model_decode(input logic [31:0] a);
        logic [32:0] lo, hi;
        for (int i = 0; i < 4; i++) begin
            lo = {1'b0, M_BASE[i]};
            hi = lo + {1'b0, M_SIZE[i]};
            if ({1'b0, a} >= lo && {1'b0, a} < hi) return i;
        end
        return -1;
    endfunction

    always @(negedge f_clk) begin
        if (chk_on) begin
            chk("m_gnt",     64'(m_gnt),     64'(e_gnt));
            chk("m_recv",    64'(m_recv),    64'(e_recv));
            chk("m_error",   64'(m_error),   64'(e_error));
            chk("m_rdata",   64'(m_rdata),   64'(e_rdata));
            chk("s_req",     64'(s_req),     64'(e_sreq));
            chk("s_ack",     64'(s_ack),     64'(e_sack));
            chk("s_addr",    64'(s_addr),    64'(e_saddr));
            chk("s_wen",     64'(s_wen),     64'(e_swen));
            chk("s_wdata",   64'(s_wdata),   64'(e_swdata));
            chk("s_strb",    64'(s_strb),    64'(e_sstrb));
            chk("err_valid", 64'(err_valid), 64'(e_valid));
            chk("err_addr",  64'(err_addr),  64'(e_eaddr));
            if (m_recv && m_ack) begin
                last_rdata = m_rdata;
                last_error = m_error;
            end
        end
    end

    // Advance one cycle: apply the error-register rules for the edge, then idle everything
    task automatic tick();
        @(posedge f_clk);
        #1;
        if (pend_rst) begin
            e_valid = 1'b0;
            e_eaddr = 32'h0;
        end else if (pend_clr) begin
            e_valid = 1'b0;
        end else if (pend_cap && !e_valid) begin
            e_valid = 1'b1;
            e_eaddr = pend_addr;
        end
        pend_rst = 1'b0; pend_clr = 1'b0; pend_cap = 1'b0;
        g_reset = 1'b0; err_clr = 1'b0;
        m_req = 1'b0; m_wen = 1'b0; m_strb = 4'h0; m_addr = 32'h0; m_wdata = 32'h0; m_ack = 1'b0;
        s_gnt = 4'h0; s_recv = 4'h0; s_error = 4'h0; s_rdata = 128'h0;
        e_gnt = 1'b0; e_recv = 1'b0; e_error = 1'b0; e_rdata = 32'h0;
        e_sreq = 4'h0; e_sack = 4'h0; e_saddr = 32'h0; e_swen = 1'b0; e_swdata = 32'h0; e_sstrb = 4'h0;
    endtask

    task automatic req_phase(input logic [31:0] a, input logic wen, input int gnt_wait, output int k);
        int gw;
        k  = model_decode(a);
        gw = (k < 0) ? 0 : gnt_wait;
        for (int c = 0; c <= gw; c++) begin
            tick();
            m_req = 1'b1; m_wen = wen; m_addr = a; m_wdata = ~a;
            m_strb = wen ? 4'b0011 : 4'hF;
            e_saddr = a; e_swen = wen; e_swdata = ~a; e_sstrb = m_strb;
            if (k >= 0) begin
                e_sreq = 4'(1 << k);
                s_gnt  = (c == gw) ? 4'(1 << k) : ~4'(1 << k);
                e_gnt  = (c == gw);
            end else begin
                s_gnt = 4'h0;
                e_gnt = 1'b1;
            end
        end
    endtask

    task automatic resp_slave(input int k, input int resp_wait, input int ack_wait,
                              input logic [31:0] rd, input logic serr);
        for (int c = 0; c < resp_wait; c++) begin
            tick();
            m_ack = 1'b1; e_sack = 4'(1 << k);
            s_recv = ~4'(1 << k); s_error = ~4'(1 << k);
            s_rdata = {4{32'hBAD0_0BAD}}; s_rdata[k*32 +: 32] = 32'h0;
        end
        for (int c = 0; c <= ack_wait; c++) begin
            tick();
            m_ack = (c == ack_wait);
            s_recv = 4'(1 << k); s_error = serr ? 4'(1 << k) : 4'h0;
            s_rdata = {4{32'hBAD0_0BAD}}; s_rdata[k*32 +: 32] = rd;
            e_recv = 1'b1; e_error = serr; e_rdata = rd;
            e_sack = m_ack ? 4'(1 << k) : 4'h0;
        end
    endtask

    task automatic resp_miss(input logic [31:0] a, input int ack_wait, input logic clr);
        for (int c = 0; c <= ack_wait; c++) begin
            tick();
            m_ack = (c == ack_wait);
            s_recv = 4'hF; s_rdata = {4{32'h5A5A_A5A5}};
            e_recv = 1'b1; e_error = 1'b1; e_rdata = 32'h0;
        end
        pend_cap = 1'b1; pend_addr = a;
        err_clr = clr; pend_clr = clr;
    endtask

    task automatic xact(input logic [31:0] a, input logic wen, input int gnt_wait, input int resp_wait,
                        input int ack_wait, input logic [31:0] rd, input logic serr);
        int k;
        req_phase(a, wen, gnt_wait, k);
        if (k >= 0) resp_slave(k, resp_wait, ack_wait, rd, serr);
        else        resp_miss(a, ack_wait, 1'b0);
    endtask

`ifdef SCARV_SOC_PERIPH_BUS_TIMEOUT_EN
    // Slave never answers in WAIT; flush_resp < 0 means it never answers in FLUSH either
    task automatic timeout_case(input logic [31:0] a, input int flush_resp);
        int k;
        req_phase(a, 1'b0, 0, k);
        for (int c = 0; c < TMO; c++) begin
            tick();
            m_ack = 1'b1; e_sack = 4'(1 << k);
        end
        tick();
        m_ack = 1'b1; e_recv = 1'b1; e_error = 1'b1;
        pend_cap = 1'b1; pend_addr = a;
        for (int c = 0; c < TMO; c++) begin
            tick();
            e_sack = 4'(1 << k);
            if (c == flush_resp) begin
                s_recv = 4'(1 << k); s_rdata[k*32 +: 32] = 32'h1234_5678;
                break;
            end
        end
        tick();
        s_recv = 4'(1 << k);
    endtask
`endif

    initial begin
        g_reset = 1'b1; err_clr = 1'b0;
        m_req = 1'b0; m_wen = 1'b0; m_strb = 4'h0; m_addr = 32'h0; m_wdata = 32'h0; m_ack = 1'b0;
        s_gnt = 4'h0; s_recv = 4'h0; s_error = 4'h0; s_rdata = 128'h0;
        repeat (3) @(posedge f_clk);
        tick();
        chk_on = 1'b1;
        tick();

        xact(32'h1000_1004, 1'b0, 1, 1, 0, 32'hDEAD_BEEF, 1'b0);
        tick();
        chk("rd_s1_data", 64'(last_rdata), 64'(32'hDEAD_BEEF));
        chk("rd_s1_err",  64'(last_error), 64'(1'b0));

        xact(32'h2000_0000, 1'b1, 0, 0, 0, 32'h0, 1'b0);
        tick();
        chk("miss_valid", 64'(err_valid), 64'(1'b1));
        chk("miss_addr",  64'(err_addr),  64'(32'h2000_0000));

        xact(32'h1000_0FFF, 1'b1, 0, 0, 2, 32'h0000_00A5, 1'b1);
        xact(32'h1000_0010, 1'b0, 2, 0, 0, 32'h0000_0010, 1'b0);
        xact(32'h1000_5000, 1'b0, 0, 3, 1, 32'hCAFE_F00D, 1'b0);
        xact(32'h1000_8000, 1'b0, 0, 0, 0, 32'h0, 1'b0);
        tick();
        chk("hold_addr", 64'(err_addr), 64'(32'h2000_0000));

        begin
            int k;
            req_phase(32'hFFFF_FFFF, 1'b1, 0, k);
            resp_miss(32'hFFFF_FFFF, 0, 1'b1);
        end
        tick();
        chk("clr_wins", 64'(err_valid), 64'(1'b0));

        xact(32'h0000_0000, 1'b0, 0, 0, 1, 32'h0, 1'b0);

`ifdef SCARV_SOC_PERIPH_BUS_TIMEOUT_EN
        err_clr = 1'b1; pend_clr = 1'b1;
        timeout_case(32'h1000_2008, 2);
        xact(32'h1000_0100, 1'b0, 0, 0, 0, 32'h0BAD_CAFE, 1'b0);
        tick();
        chk("after_flush", 64'(last_rdata), 64'(32'h0BAD_CAFE));
        chk("tmo_addr",    64'(err_addr),   64'(32'h1000_2008));
        timeout_case(32'h1000_2000, -1);
`else
        xact(32'h1000_2008, 1'b0, 0, 30, 0, 32'h7777_1111, 1'b0);
`endif
        xact(32'h1000_3004, 1'b1, 0, 0, 0, 32'h0, 1'b0);

        begin
            int k;
            req_phase(32'h1000_1000, 1'b0, 0, k);
        end
        tick();
        g_reset = 1'b1; pend_rst = 1'b1;
        tick();
        s_recv = 4'b0010; s_rdata[63:32] = 32'hFFFF_0000; m_ack = 1'b1;
        tick();
        chk("rst_valid", 64'(err_valid), 64'(1'b0));
        xact(32'h1000_1008, 1'b0, 0, 0, 0, 32'h3141_5926, 1'b0);
        tick();
        chk("post_rst_data", 64'(last_rdata), 64'(32'h3141_5926));
        tick();

        chk_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/scarv_soc_periph_bus.md
# scarv_soc_periph_bus

Parametrised single-master, N-slave memory-interface router between the core complex external memory port and the SoC peripheral sub-system (UART, GPIO, and further peripherals). It decodes each request address against per-slave base/size windows and forwards one outstanding transaction at a time. Unmapped or non-responding accesses are answered with a bus error, and the faulting address is captured for software.

## Interface
Parameters:
- NUM_SLV, 4: number of downstream slave ports, 1..16.
- ADDR_W, 32: address width.
- DATA_W, 32: data width, a multiple of 8. Strobe width is DATA_W/8.
- SLV_BASE, {0x1000_3000, 0x1000_2000, 0x1000_1000, 0x1000_0000}: packed NUM_SLV*ADDR_W. Slot i occupies bits [i*ADDR_W +: ADDR_W].
- SLV_SIZE, all 0x0000_1000: packed NUM_SLV*ADDR_W window sizes in bytes.
- TIMEOUT, 255: cycles to wait for a slave response, 1..65535.

Ports:
- f_clk  in  1  clock.
- g_reset  in  1  synchronous active-high reset.
- m_req / m_gnt  in / out  1  upstream request handshake.
- m_wen, m_strb, m_addr, m_wdata  in  1, DATA_W/8, ADDR_W, DATA_W  upstream request fields.
- m_recv / m_ack  out / in  1  upstream response handshake.
- m_error, m_rdata  out  1, DATA_W  upstream response fields.
- s_req / s_gnt  out / in  NUM_SLV  per-slave request handshake.
- s_wen, s_strb, s_addr, s_wdata  out  shared  request fields broadcast to all slaves.
- s_recv / s_ack  in / out  NUM_SLV  per-slave response handshake.
- s_error, s_rdata  in  NUM_SLV, NUM_SLV*DATA_W  per-slave response fields.
- err_valid, err_addr  out  1, ADDR_W  sticky captured-error flag and address.
- err_clr  in  1  clears err_valid.

## Operation
- Handshakes:
  - A request transfers when req&gnt are high in the same cycle.
  - A response transfers when recv&ack are high in the same cycle.
  - Request fields are held stable while req&!gnt.
- Decode: slave i hits when m_addr >= base_i and (m_addr - base_i) < size_i, computed at ADDR_W bits with no overflow wrap. If several slaves hit, the lowest index wins.
- IDLE:
  - Hit on slave k: s_req[k] = m_req and m_gnt = s_gnt[k], both combinational. All other s_req bits are 0.
  - On transfer: sel <= k, counter cleared, go to WAIT.
  - Miss: m_gnt = m_req. On transfer go to ERR. No s_req is asserted.
- WAIT:
  - m_recv = s_recv[sel], m_error = s_error[sel], m_rdata = s_rdata[sel], s_ack[sel] = m_ack. m_gnt = 0.
  - On transfer go to IDLE.
  - Counter increments each cycle without s_recv[sel]. When it reaches TIMEOUT, go to ERR.
- ERR:
  - m_recv = 1, m_error = 1, m_rdata = 0.
  - On m_ack: capture the address into err_addr if err_valid is 0, and set err_valid.
  - Next state is FLUSH if ERR was entered by timeout, otherwise IDLE.
- FLUSH:
  - s_ack[sel] = 1 to absorb the late response. m_gnt = 0.
  - Exit to IDLE when s_recv[sel] is seen, or after a further TIMEOUT cycles.
- The request address is registered on accept for error capture.
- err_clr has priority over a simultaneous capture: the flag clears and the capture is lost.

## Timing
- Reset values: state IDLE, sel 0, counter 0, err_valid 0, err_addr 0. All combinational outputs are 0 while no request is pending.
- Request path: zero added latency (combinational gnt).
- Response path:
  - Earliest response is the cycle after the request transfer. A slave recv is passed through in the same cycle.
  - Miss response is asserted the cycle after the transfer.
  - Timeout: error recv is asserted TIMEOUT+1 cycles after the transfer.
- Back-to-back: a new request may transfer in the cycle after a response transfer.
- g_reset mid-transaction returns to IDLE next edge. A slave left mid-response is not acked.

## Configuration
- SCARV_SOC_PERIPH_BUS_TIMEOUT_EN:
  - Defined: timeout counter, ERR-by-timeout, and the FLUSH state are present.
  - Undefined: WAIT persists until a slave response, and the TIMEOUT parameter is ignored. FLUSH and the counter are not synthesised. Miss errors still occur.

## Structure
- Shared package scarv_soc_pkg holds:
  - the state enum (IDLE, WAIT, ERR, FLUSH);
  - the default UART/GPIO base-address constants;
  - the slave-index width function, clog2(NUM_SLV).
- One sub-module, scarv_soc_periph_bus_decode: combinational address-to-one-hot decoder with priority encode, plus a hit flag.

## Test plan
- Read slave 1 at 0x1000_1004: s_gnt[1] high, s_rdata[1]=0xDEADBEEF two cycles later -> m_recv, m_rdata=0xDEADBEEF, m_error=0. No other s_req bit toggles.
- Write to 0x2000_0000 (unmapped) -> m_gnt in the same cycle, m_recv+m_error the next cycle, err_valid=1, err_addr=0x2000_0000.
- Slave 2 never responds, TIMEOUT=8 -> error response 9 cycles after the accept. The slave's late recv in FLUSH is acked and not forwarded. The next request is then serviced.
- Overlapping windows for slaves 0 and 3 both containing 0x1000_0010 -> only s_req[0] is asserted.
- Two errors without err_clr -> err_addr holds the first address. Then err_clr in the same cycle as a third error capture -> err_valid=0.
- g_reset asserted in WAIT -> next cycle m_gnt=0, m_recv=0, err_valid=0, and a following request is accepted normally.
